// File: rtl/outport_arbiter_pkg.sv
// Types, widths and the control-word builder shared by the output-port arbiter.
// All field widths come from noc_pkt.vh so the arbiter tracks the packet format.
`include "noc_pkt.vh"

package outport_arbiter_pkg;

  localparam int DATA_W   = `DATAWIDTH;
  localparam int DEST_W   = `DESTWIDTH;
  localparam int TAIL_BIT = `TAILBIT;
  localparam int NH_W     = `NEXTHOPWIDTH;
  localparam int NH_BIT   = `NEXTHOPBIT;
  localparam int CTRL_W   = `CTRLWIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

  function automatic logic [CTRL_W-1:0] make_ctrl(
    input logic [DEST_W-1:0] dest,
    input logic              tail,
    input logic [NH_W-1:0]   nh
  );
    logic [CTRL_W-1:0] c;
    c                  = '0;
    c[DEST_W-1:0]      = dest;
    c[TAIL_BIT]        = tail;
    c[NH_BIT +: NH_W]  = nh;
    return c;
  endfunction

endpackage

// File: rtl/noc_pkt.vh
// Shared NoC flit field widths and control-word bit positions.
// The control word is {next-hop select, tail, dest} from MSB to LSB.
`ifndef NOC_PKT_VH
`define NOC_PKT_VH
`define DATAWIDTH    32
`define DESTWIDTH    4
`define TAILBIT      `DESTWIDTH
`define NEXTHOPWIDTH 5
`define NEXTHOPBIT   (`DESTWIDTH+1)
`define CTRLWIDTH    (`NEXTHOPBIT+`NEXTHOPWIDTH)
`endif

// File: rtl/outport_arbiter_rr_pick.sv
// Round-robin priority pick: first requester at or after i_ptr, wrapping.
// Purely combinational; o_gnt is zero when nothing requests.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    o_gnt = '0;
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!found && i_req[j]) begin
        found    = 1'b1;
        o_idx    = IW'(j);
        o_gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outport_arbiter.sv
// Output-port arbiter: round-robin packet-locked grant over NUM_IN FIFO heads, pops same cycle, output registered one cycle later.
// Stalls without pop or grant change when out_sendok=0; define OUTPORT_ARB_STATS_EN for pkt_count/stall_count.
`include "noc_pkt.vh"

module outport_arbiter
  import outport_arbiter_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int PORT_IDX = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_IN-1:0]                 in_avail,
  input  logic [NUM_IN*`NEXTHOPWIDTH-1:0]   in_sel,
  input  logic [NUM_IN*`DATAWIDTH-1:0]      in_q,
  input  logic [NUM_IN*(`DESTWIDTH+1)-1:0]  in_controlq,
  input  logic [NUM_IN*`NEXTHOPWIDTH-1:0]   in_to,
  output logic [NUM_IN-1:0]                 in_rd,
  input  logic                              out_sendok,
  output logic                              out_we,
  output logic [`DATAWIDTH-1:0]             out_d,
  output logic [`CTRLWIDTH-1:0]             out_control,
  output logic                              busy
`ifdef OUTPORT_ARB_STATS_EN
  ,
  output logic [15:0]                       pkt_count,
  output logic [15:0]                       stall_count
`endif
);

  localparam int IW = $clog2(NUM_IN);
  localparam int CW = DEST_W + 1;

  arb_state_t          r_state;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_owner;
  logic                r_busy;
  logic                r_out_we;
  logic [DATA_W-1:0]   r_out_d;
  logic [CTRL_W-1:0]   r_out_ctrl;

  logic [NUM_IN-1:0]   w_req;
  logic [NUM_IN-1:0]   w_pick_gnt;
  logic [IW-1:0]       w_pick_idx;
  logic [IW-1:0]       w_ptr;
  logic [IW-1:0]       w_gnt;
  logic [NUM_IN-1:0]   w_rd;
  logic                w_pop;
  logic [DATA_W-1:0]   w_d;
  logic [DEST_W-1:0]   w_dest;
  logic                w_tail;
  logic [NH_W-1:0]     w_to;
  logic                w_unused_sel;

  // Only this port's bit of each sel bus matters here.
  assign w_unused_sel = ^in_sel;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_req[i] = in_avail[i] & in_sel[i*NH_W + PORT_IDX];
    end
  end

  assign w_ptr = (r_last == IW'(NUM_IN-1)) ? '0 : r_last + IW'(1);

  rr_pick #(.N(NUM_IN), .IW(IW)) u_pick (
    .i_req (w_req),
    .i_ptr (w_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // In IDLE the fresh pick pops in the same cycle, so single-flit packets never lock.
  always_comb begin
    w_gnt = (r_state == ST_LOCK) ? r_owner : w_pick_idx;
    w_rd  = '0;
    if (!rst && out_sendok) begin
      if (r_state == ST_LOCK) w_rd[r_owner] = w_req[r_owner];
      else                    w_rd          = w_pick_gnt;
    end
  end

  assign w_pop = |w_rd;
  assign in_rd = w_rd;

  always_comb begin
    w_d    = '0;
    w_dest = '0;
    w_tail = 1'b0;
    w_to   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_gnt == IW'(i)) begin
        w_d    = in_q[i*DATA_W +: DATA_W];
        w_dest = in_controlq[i*CW +: DEST_W];
        w_tail = in_controlq[i*CW + TAIL_BIT];
        w_to   = in_to[i*NH_W +: NH_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last     <= IW'(NUM_IN-1);
      r_owner    <= '0;
      r_busy     <= 1'b0;
      r_out_we   <= 1'b0;
      r_out_d    <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_out_we <= w_pop;
      if (w_pop) begin
        r_out_d    <= w_d;
        r_out_ctrl <= make_ctrl(w_dest, w_tail, w_to);
        if (w_tail) begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_last  <= w_gnt;
        end else begin
          r_state <= ST_LOCK;
          r_busy  <= 1'b1;
          r_owner <= w_gnt;
        end
      end
    end
  end

  assign out_we      = r_out_we;
  assign out_d       = r_out_d;
  assign out_control = r_out_ctrl;
  assign busy        = r_busy;

`ifdef OUTPORT_ARB_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkt_cnt   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && w_tail) r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (r_state == ST_LOCK && !out_sendok && r_stall_cnt != 16'hFFFF)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign pkt_count   = r_pkt_cnt;
  assign stall_count = r_stall_cnt;
`endif

endmodule

// File: tb/tb_outport_arbiter.sv
// Randomized and directed bench for outport_arbiter against a packet-level reference model.
module tb_outport_arbiter;
  import outport_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int PIDX = 0;
  localparam int CW   = DEST_W + 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          in_avail;
  logic [N*NH_W-1:0]     in_sel;
  logic [N*DATA_W-1:0]   in_q;
  logic [N*CW-1:0]       in_controlq;
  logic [N*NH_W-1:0]     in_to;
  logic [N-1:0]          in_rd;
  logic                  out_sendok;
  logic                  out_we;
  logic [DATA_W-1:0]     out_d;
  logic [CTRL_W-1:0]     out_control;
  logic                  busy;
`ifdef OUTPORT_ARB_STATS_EN
  logic [15:0]           pkt_count;
  logic [15:0]           stall_count;
`endif

  always #5 clk = ~clk;

  outport_arbiter #(.NUM_IN(N), .PORT_IDX(PIDX)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_avail    (in_avail),
    .in_sel      (in_sel),
    .in_q        (in_q),
    .in_controlq (in_controlq),
    .in_to       (in_to),
    .in_rd       (in_rd),
    .out_sendok  (out_sendok),
    .out_we      (out_we),
    .out_d       (out_d),
    .out_control (out_control),
    .busy        (busy)
`ifdef OUTPORT_ARB_STATS_EN
    ,
    .pkt_count   (pkt_count),
    .stall_count (stall_count)
`endif
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [DEST_W-1:0] dest;
    logic              tail;
    logic [NH_W-1:0]   to;
    int                port;
  } flit_t;

  flit_t q[N][$];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: who owns the port (-1 = nobody) and who finished last.
  int          m_owner;
  int          m_last;
  logic        exp_we;
  logic [63:0] exp_d;
  logic [63:0] exp_ctrl;
  logic        exp_busy;
  int          exp_pkt;
  int          exp_stall;

  bit   checks_on  = 1'b0;
  bit   rst_drv    = 1'b1;
  int   sendok_mode = 1;
  int   avail_pct  = 100;
  int   pop_log[$];
  bit   we_log[$];
  int   rd_hits;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int total_flits();
    int t = 0;
    for (int i = 0; i < N; i++) t += q[i].size();
    return t;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < N; i++) q[i].delete();
  endtask

  task automatic push_pkt(input int i, input int len, input int port);
    flit_t fl;
    for (int f = 0; f < len; f++) begin
      fl.d    = $urandom;
      fl.dest = DEST_W'($urandom);
      fl.tail = (f == len - 1);
      fl.to   = NH_W'($urandom);
      fl.port = port;
      q[i].push_back(fl);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = N - 1;
    exp_we    = 1'b0;
    exp_d     = '0;
    exp_ctrl  = '0;
    exp_busy  = 1'b0;
    exp_pkt   = 0;
    exp_stall = 0;
  endtask

  // One clock cycle: check last cycle's registered outputs, drive, check in_rd, advance model.
  task automatic step();
    logic [N-1:0]    req_v;
    logic [N-1:0]    exp_rd;
    logic [NH_W-1:0] s;
    flit_t           fl;
    int              pop;
    int              j;
    @(negedge clk);
    if (checks_on) begin
      check_val("out_we", out_we, exp_we);
      check_val("out_d", out_d, exp_d);
      check_val("out_control", out_control, exp_ctrl);
      check_val("busy", busy, exp_busy);
`ifdef OUTPORT_ARB_STATS_EN
      check_val("pkt_count", pkt_count, exp_pkt);
      check_val("stall_count", stall_count, exp_stall);
`endif
    end
    we_log.push_back(out_we);
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        fl = q[i][0];
        s = '0;
        s[fl.port] = 1'b1;
        in_avail[i]                 = ($urandom_range(99) < avail_pct);
        in_sel[i*NH_W +: NH_W]      = s;
        in_q[i*DATA_W +: DATA_W]    = fl.d;
        in_controlq[i*CW +: CW]     = {fl.tail, fl.dest};
        in_to[i*NH_W +: NH_W]       = fl.to;
      end else begin
        in_avail[i]                 = 1'b0;
        in_sel[i*NH_W +: NH_W]      = NH_W'($urandom);
        in_q[i*DATA_W +: DATA_W]    = $urandom;
        in_controlq[i*CW +: CW]     = CW'($urandom);
        in_to[i*NH_W +: NH_W]       = NH_W'($urandom);
      end
    end
    out_sendok = (sendok_mode < 0) ? ($urandom_range(4) != 0) : (sendok_mode != 0);
    rst = rst_drv;
    #1;
    for (int i = 0; i < N; i++)
      req_v[i] = in_avail[i] && q[i].size() > 0 && q[i][0].port == PIDX;
    pop = -1;
    if (!rst_drv && out_sendok) begin
      if (m_owner >= 0) begin
        if (req_v[m_owner]) pop = m_owner;
      end else begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (pop < 0 && req_v[j]) pop = j;
        end
      end
    end
    if (!rst_drv && !out_sendok && m_owner >= 0 && exp_stall < 65535) exp_stall++;
    exp_rd = '0;
    if (pop >= 0) exp_rd[pop] = 1'b1;
    if (checks_on) check_val("in_rd", in_rd, exp_rd);
    if (in_rd != 0) rd_hits++;
    if (rst_drv) begin
      model_reset();
    end else begin
      exp_we = (pop >= 0);
      if (pop >= 0) begin
        fl = q[pop].pop_front();
        pop_log.push_back(pop);
        exp_d    = 64'(fl.d);
        exp_ctrl = (64'(fl.to) << NH_BIT) | (64'(fl.tail) << DEST_W) | 64'(fl.dest);
        if (fl.tail) begin
          m_owner = -1;
          m_last  = pop;
          exp_pkt = (exp_pkt + 1) % 65536;
        end else begin
          m_owner = pop;
        end
      end
      exp_busy = (m_owner >= 0);
    end
  endtask

  task automatic drain(input int max_cycles);
    int c = 0;
    while (total_flits() > 0 && c < max_cycles) begin
      step();
      c++;
    end
    step();
    check_val("drain_left", total_flits(), 0);
  endtask

  task automatic reset_pulse();
    clear_queues();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
  endtask

  initial begin
    int exp_seq[$];
    int run;
    int best;
    in_avail = '0; in_sel = '0; in_q = '0; in_controlq = '0; in_to = '0;
    out_sendok = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    checks_on = 1'b1;

    // Reset state, with a request pending that must not be popped.
    push_pkt(0, 2, PIDX);
    step();
    step();
    clear_queues();
    rst_drv = 1'b0;

    // Two 3-flit packets drain back-to-back.
    push_pkt(0, 3, PIDX);
    push_pkt(2, 3, PIDX);
    pop_log.delete();
    we_log.delete();
    drain(20);
    exp_seq = '{0, 0, 0, 2, 2, 2};
    check_val("b2b_pops", pop_log.size(), 6);
    for (int k = 0; k < 6 && k < pop_log.size(); k++) check_val("b2b_order", pop_log[k], exp_seq[k]);
    best = 0; run = 0;
    foreach (we_log[k]) begin
      run  = we_log[k] ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    check_val("b2b_we_run", best, 6);

    // Single-flit packets on every input rotate 0,1,2,3,0.
    reset_pulse();
    for (int i = 0; i < N; i++) push_pkt(i, 1, PIDX);
    for (int i = 0; i < N; i++) push_pkt(i, 1, PIDX);
    pop_log.delete();
    drain(20);
    exp_seq = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 5; k++) check_val("rotate", pop_log[k], exp_seq[k]);

    // sendok low for 5 cycles mid-packet.
    reset_pulse();
    push_pkt(1, 4, PIDX);
    step();
    sendok_mode = 0;
    rd_hits = 0;
    repeat (5) step();
    check_val("stall_no_rd", rd_hits, 0);
    sendok_mode = 1;
    drain(20);
`ifdef OUTPORT_ARB_STATS_EN
    check_val("stall_count5", stall_count, 5);
`endif

    // Input 3 must wait for input 1's locked packet.
    reset_pulse();
    push_pkt(1, 3, PIDX);
    pop_log.delete();
    step();
    push_pkt(3, 1, PIDX);
    drain(20);
    exp_seq = '{1, 1, 1, 3};
    for (int k = 0; k < 4; k++) check_val("lock_hold", pop_log[k], exp_seq[k]);

    // Reset while locked aborts the packet and re-arms the pointer at input 0.
    reset_pulse();
    push_pkt(0, 3, PIDX);
    step();
    step();
    clear_queues();
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    push_pkt(1, 1, PIDX);
    push_pkt(0, 1, PIDX);
    pop_log.delete();
    drain(20);
    check_val("rst_first", pop_log[0], 0);
    check_val("rst_second", pop_log[1], 1);

    // Request aimed at another port index is ignored.
    reset_pulse();
    push_pkt(2, 2, PIDX + 1);
    rd_hits = 0;
    repeat (5) step();
    check_val("other_port_rd", rd_hits, 0);
    clear_queues();
    step();

    // Random traffic with avail dropouts and sendok stalls.
    reset_pulse();
    avail_pct   = 70;
    sendok_mode = -1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0) begin
        int i;
        i = $urandom_range(N - 1);
        if (q[i].size() < 6) push_pkt(i, $urandom_range(1, 4), PIDX);
      end
      step();
    end
    avail_pct   = 100;
    sendok_mode = 1;
    drain(200);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/outport_arbiter.md
OUTPORT_ARBITER -- requirements
Module: outport_arbiter

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of input FIFOs competing for this output port, range 2..8.
REQ-002 SHALL have parameter PORT_IDX, default 0: index of the sel bit, within each FIFO's `NEXTHOPWIDTH-wide sel bus, that requests this port.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_avail, input, NUM_IN bits: per-FIFO flag meaning the FIFO's head register holds a valid flit.
REQ-006 SHALL have port in_sel, input, NUM_IN*`NEXTHOPWIDTH bits: per-FIFO one-hot next-hop request.
REQ-007 SHALL have port in_q, input, NUM_IN*`DATAWIDTH bits: per-FIFO head data.
REQ-008 SHALL have port in_controlq, input, NUM_IN*(`DESTWIDTH+1) bits: per-FIFO head control; bits [`DESTWIDTH-1:0] are dest, bit `DESTWIDTH is the tail flag.
REQ-009 SHALL have port in_to, input, NUM_IN*`NEXTHOPWIDTH bits: per-FIFO next-next-hop select, copied from the FIFO's to slice for this port.
REQ-010 SHALL have port in_rd, output, NUM_IN bits: per-FIFO pop strobe.
REQ-011 SHALL have port out_sendok, input, 1 bit: the downstream FIFO's sendok.
REQ-012 SHALL have port out_we, output, 1 bit: write strobe to the downstream FIFO.
REQ-013 SHALL have port out_d, output, `DATAWIDTH bits: flit data to the downstream FIFO.
REQ-014 SHALL have port out_control, output, `CTRLWIDTH bits: the downstream FIFO's control input.
REQ-015 SHALL have port busy, output, 1 bit: high while a packet holds the grant.

Function
REQ-016 SHALL treat input i as requesting when in_avail[i] && in_sel[i*`NEXTHOPWIDTH+PORT_IDX].
REQ-017 SHALL implement a two-state FSM: IDLE -> LOCK when a grant is issued; LOCK -> IDLE on the cycle the tail flit is popped.
REQ-018 SHALL, in IDLE, grant round-robin, starting the search at (last_grant+1) mod NUM_IN, and issue no grant when out_sendok=0.
REQ-019 SHALL, in LOCK, hold the grant on one input until its tail is transferred, even if other inputs request.
REQ-020 SHALL assert in_rd[g] combinationally iff g is granted, input g is requesting, and out_sendok=1.
REQ-021 SHALL assert at most one bit of in_rd in any cycle.
REQ-022 SHALL, on every pop, register out_we=1 and out_d=in_q[g] one cycle later.
REQ-023 SHALL, on every pop, form out_control as: dest and tail at [`DESTWIDTH:0], in_to[g] at [`NEXTHOPBIT +: `NEXTHOPWIDTH], and all other bits 0.
REQ-024 SHALL register out_we=0 in every cycle with no pop, and SHALL then hold out_d and out_control at their previous values.
REQ-025 SHALL allow a single-flit packet (tail set on the first flit) to be granted and released in the same cycle, returning to IDLE next cycle.
REQ-026 SHALL, when out_sendok drops mid-packet, stall with no pop and no grant change, and resume on the first cycle out_sendok=1.
REQ-027 SHALL, if the granted input's in_avail drops mid-packet, keep the grant and wait with no pop.
REQ-028 SHALL update last_grant only when the tail is popped, so the round-robin pointer wraps from NUM_IN-1 to 0.

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, last_grant=NUM_IN-1, and in_rd=0.
REQ-030 SHALL, while rst=1, force out_we=0, out_d=0, out_control=0, busy=0.
REQ-031 SHALL abort any locked packet on reset mid-packet, with no partial flush.

Configuration
REQ-032 SHALL use the macro OUTPORT_ARB_STATS_EN to compile the statistics feature in or out.
REQ-033 SHALL, with OUTPORT_ARB_STATS_EN defined, add output pkt_count (16 bits, +1 per tail pop, wrapping) and output stall_count (16 bits, +1 per LOCK cycle with out_sendok=0, saturating at 16'hFFFF); both reset to 0.
REQ-034 SHALL, without OUTPORT_ARB_STATS_EN, have neither port nor the counter logic.

Structure
REQ-035 SHALL take `DATAWIDTH, `DESTWIDTH, `NEXTHOPWIDTH, `NEXTHOPBIT and `CTRLWIDTH from noc_pkt.vh, and SHALL add the tail-bit position (`TAILBIT = `DESTWIDTH) there rather than hard-coding it.
REQ-036 SHALL place the round-robin priority selection in one sub-module, rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index).

Verification
REQ-037 SHALL cover: NUM_IN=4, inputs 0 and 2 each request a 3-flit packet, sendok=1 -> input 0's 3 flits, then input 2's 3 flits, back-to-back, with out_we high for 6 consecutive cycles.
REQ-038 SHALL cover: all 4 inputs request single-flit packets continuously -> grants rotate 0,1,2,3,0 with one flit per cycle.
REQ-039 SHALL cover: out_sendok=0 for 5 cycles mid-packet -> no in_rd and out_we=0 in that window, flit order preserved, and stall_count=5 when stats are enabled.
REQ-040 SHALL cover: input 1 locked, then input 3 requests -> in_rd[3]=0 until input 1's tail is popped.
REQ-041 SHALL cover: rst asserted during LOCK -> next cycle state IDLE, out_we=0, and last_grant=3.
REQ-042 SHALL cover: in_sel request bit set on a different port index -> no grant and no in_rd.
